rom_scan_reader: RTL

Parametrised successor to `rom_reader`. Drives a ROM chip through serial shift registers: the address goes out on a SIPO chain and the data comes back on a PISO chain. Supports manual single-word stepping (increment/decrement) and an automatic full-chip dump. Each word read is presented on a valid/ready stream to the downstream dump/transport logic.

---
 rtl/rom_reader_pkg.sv | 44 ++++
 rtl/rom_serial_link.sv | 90 +++++++++
 rtl/rom_scan_reader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rom_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rom_reader_pkg
// Brief   : State codes, bit-phase/direction constants and latency helper
//           shared by the ROM scan reader and its serial link engine.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package rom_reader_pkg;

  localparam logic [3:0] OP_IDLE       = 4'd0;
  localparam logic [3:0] OP_SHIFT_ADDR = 4'd1;
  localparam logic [3:0] OP_LATCH      = 4'd2;
  localparam logic [3:0] OP_SETTLE     = 4'd3;
  localparam logic [3:0] OP_LOAD       = 4'd4;
  localparam logic [3:0] OP_SHIFT_DATA = 4'd5;
  localparam logic [3:0] OP_PRESENT    = 4'd6;
  localparam logic [3:0] OP_DONE       = 4'd7;

  typedef enum logic [3:0] {
    ST_IDLE       = OP_IDLE,
    ST_SHIFT_ADDR = OP_SHIFT_ADDR,
    ST_LATCH      = OP_LATCH,
    ST_SETTLE     = OP_SETTLE,
    ST_LOAD       = OP_LOAD,
    ST_SHIFT_DATA = OP_SHIFT_DATA,
    ST_PRESENT    = OP_PRESENT,
    ST_DONE       = OP_DONE
  } state_e;

  localparam logic PHASE_A = 1'b0;
  localparam logic PHASE_B = 1'b1;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  // Cycles from the command-sampling edge to the first data_valid cycle.
  function automatic int unsigned read_latency(input int unsigned aw,
                                               input int unsigned dw,
                                               input int unsigned ac);
    return 2 * aw + 2 * dw + ac + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_serial_link.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rom_serial_link
// Brief   : Two-phase serial bit engine (phase A data, phase B shift clock),
//           MSB first, usable as a SIPO driver or a PISO receiver.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module rom_serial_link
  import rom_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic        DIR   = DIR_OUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic             sclk_o,
  output logic             done_o,
  output logic [WIDTH-1:0] value_o
);

  localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  logic             busy_q,  busy_d;
  logic             phase_q, phase_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sclk_q,  sclk_d;

  // Outbound shifts after the clock pulse so the line holds through phase B;
  // inbound samples at the end of phase A, before the chain is clocked.
  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sclk_d  = 1'b0;
    if (start_i) begin
      busy_d  = 1'b1;
      phase_d = PHASE_A;
      cnt_d   = '0;
      shreg_d = load_i;
    end else if (busy_q) begin
      if (phase_q == PHASE_A) begin
        phase_d = PHASE_B;
        sclk_d  = 1'b1;
        if (DIR == DIR_IN) begin
          shreg_d = (shreg_q << 1) | WIDTH'(serial_i);
        end
      end else begin
        phase_d = PHASE_A;
        if (DIR == DIR_OUT) begin
          shreg_d = (shreg_q << 1) | WIDTH'(serial_i);
        end
        if (cnt_q == LAST_BIT) begin
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      phase_q <= PHASE_A;
      cnt_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
    end
  end

  assign done_o   = busy_q && (phase_q == PHASE_B) && (cnt_q == LAST_BIT);
  assign serial_o = shreg_q[WIDTH-1];
  assign sclk_o   = sclk_q;
  assign value_o  = shreg_q;

endmodule
`default_nettype wire

// File: rtl/rom_scan_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rom_scan_reader
// Brief   : Reads a ROM through SIPO/PISO chains, with manual stepping and a
//           full-chip scan, presenting each word on a valid/ready stream.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module rom_scan_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     increment_address,
  input  logic                     decrement_address,
  input  logic                     start_scan,
  input  logic                     data_line_in,
  output logic                     address_line,
  output logic                     address_sclk,
  output logic                     address_latch,
  output logic                     data_load,
  output logic                     data_sclk,
  output logic [3:0]               operation,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [ADDRESS_WIDTH-1:0] data_address,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     scan_done
);

  localparam int unsigned              SW          = $clog2(ACCESS_CYCLES + 1);
  localparam logic [SW-1:0]            SETTLE_LAST = SW'(ACCESS_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX    = '1;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     scan_q, scan_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] data_addr_q, data_addr_d;
  logic                     latch_q, load_q, valid_q, done_q;

  logic                     w_addr_start, w_addr_done;
  logic                     w_data_start, w_data_done;
  logic [DATA_WIDTH-1:0]    w_data_value;
  logic [ADDRESS_WIDTH-1:0] w_unused_addr_value;
  logic                     w_unused_data_line;

  rom_serial_link #(
    .WIDTH (ADDRESS_WIDTH),
    .DIR   (DIR_OUT)
  ) u_addr_link (
    .clk      (clk),
    .reset    (reset),
    .start_i  (w_addr_start),
    .load_i   (addr_d),
    .serial_i (1'b0),
    .serial_o (address_line),
    .sclk_o   (address_sclk),
    .done_o   (w_addr_done),
    .value_o  (w_unused_addr_value)
  );

  rom_serial_link #(
    .WIDTH (DATA_WIDTH),
    .DIR   (DIR_IN)
  ) u_data_link (
    .clk      (clk),
    .reset    (reset),
    .start_i  (w_data_start),
    .load_i   ('0),
    .serial_i (data_line_in),
    .serial_o (w_unused_data_line),
    .sclk_o   (data_sclk),
    .done_o   (w_data_done),
    .value_o  (w_data_value)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    scan_d       = scan_q;
    settle_d     = settle_q;
    data_d       = data_q;
    data_addr_d  = data_addr_q;
    w_addr_start = 1'b0;
    w_data_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_scan) begin
          addr_d       = '0;
          scan_d       = 1'b1;
          state_d      = ST_SHIFT_ADDR;
          w_addr_start = 1'b1;
        end else if (increment_address && !decrement_address) begin
          addr_d       = addr_q + ADDRESS_WIDTH'(1);
          scan_d       = 1'b0;
          state_d      = ST_SHIFT_ADDR;
          w_addr_start = 1'b1;
        end else if (decrement_address && !increment_address) begin
          addr_d       = addr_q - ADDRESS_WIDTH'(1);
          scan_d       = 1'b0;
          state_d      = ST_SHIFT_ADDR;
          w_addr_start = 1'b1;
        end
      end
      ST_SHIFT_ADDR: begin
        if (w_addr_done) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_LOAD;
        else settle_d = settle_q + SW'(1);
      end
      ST_LOAD: begin
        w_data_start = 1'b1;
        state_d      = ST_SHIFT_DATA;
      end
      ST_SHIFT_DATA: begin
        if (w_data_done) begin
          data_d      = w_data_value;
          data_addr_d = addr_q;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (data_ready) begin
          if (!scan_q) begin
            state_d = ST_IDLE;
          end else if (addr_q == ADDR_MAX) begin
            state_d = ST_DONE;
          end else begin
            addr_d       = addr_q + ADDRESS_WIDTH'(1);
            state_d      = ST_SHIFT_ADDR;
            w_addr_start = 1'b1;
          end
        end
      end
      ST_DONE: begin
        scan_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      scan_q      <= 1'b0;
      settle_q    <= '0;
      data_q      <= '0;
      data_addr_q <= '0;
      latch_q     <= 1'b0;
      load_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      scan_q      <= scan_d;
      settle_q    <= settle_d;
      data_q      <= data_d;
      data_addr_q <= data_addr_d;
      latch_q     <= (state_d == ST_LATCH);
      load_q      <= (state_d == ST_LOAD);
      valid_q     <= (state_d == ST_PRESENT);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign operation     = state_q;
  assign address_latch = latch_q;
  assign data_load     = load_q;
  assign data_valid    = valid_q;
  assign scan_done     = done_q;
  assign data_out      = data_q;
  assign data_address  = data_addr_q;

endmodule
`default_nettype wire
